// File: rtl/stopwatch_core.sv
// BCD minutes:seconds timekeeping core: counts on the 1 Hz enable, steps the
// selected field on the 2 Hz enable in adjust mode, and blinks that field.
module stopwatch_core #(
    parameter int unsigned MIN_MAX = 99,
    parameter int unsigned SEC_MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       one_hz_tick,
    input  logic       two_hz_tick,
    input  logic       blink_tick,
    input  logic       pause_pulse,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       blank_min,
    output logic       blank_sec,
    output logic       paused
);

    localparam logic [7:0] MIN_MAX_BCD = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};
    localparam logic [7:0] SEC_MAX_BCD = {4'(SEC_MAX / 10), 4'(SEC_MAX % 10)};

    // Two-digit BCD increment that wraps to 00 after the field maximum.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
        if (v == vmax)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    logic [7:0] min_q, min_d;
    logic [7:0] sec_q, sec_d;
    logic       paused_q, paused_d;
    logic       phase_q, phase_d;
    logic       blank_min_q, blank_min_d;
    logic       blank_sec_q, blank_sec_d;

    always_comb begin
        min_d    = min_q;
        sec_d    = sec_q;
        paused_d = paused_q ^ pause_pulse;
        phase_d  = adj ? (phase_q ^ blink_tick) : 1'b0;

        if (!adj) begin
            // Counting uses the pause state before any same-cycle toggle.
            if (one_hz_tick && !paused_q) begin
                sec_d = bcd_inc(sec_q, SEC_MAX_BCD);
                if (sec_q == SEC_MAX_BCD)
                    min_d = bcd_inc(min_q, MIN_MAX_BCD);
            end
        end else if (two_hz_tick) begin
            if (sel)
                sec_d = bcd_inc(sec_q, SEC_MAX_BCD);
            else
                min_d = bcd_inc(min_q, MIN_MAX_BCD);
        end

        // Flags follow the new phase so a blink edge shows one cycle after its tick.
        blank_min_d = adj & ~sel & phase_d;
        blank_sec_d = adj & sel & phase_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min_q       <= '0;
            sec_q       <= '0;
            paused_q    <= 1'b0;
            phase_q     <= 1'b0;
            blank_min_q <= 1'b0;
            blank_sec_q <= 1'b0;
        end else begin
            min_q       <= min_d;
            sec_q       <= sec_d;
            paused_q    <= paused_d;
            phase_q     <= phase_d;
            blank_min_q <= blank_min_d;
            blank_sec_q <= blank_sec_d;
        end
    end

    assign min_tens  = min_q[7:4];
    assign min_ones  = min_q[3:0];
    assign sec_tens  = sec_q[7:4];
    assign sec_ones  = sec_q[3:0];
    assign blank_min = blank_min_q;
    assign blank_sec = blank_sec_q;
    assign paused    = paused_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: directed scenarios plus random enables, checked
// every cycle against an integer minutes/seconds reference model.
module tb_stopwatch_core;

    localparam int MIN_MAX = 99;
    localparam int SEC_MAX = 59;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       one_hz_tick = 1'b0;
    logic       two_hz_tick = 1'b0;
    logic       blink_tick = 1'b0;
    logic       pause_pulse = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       blank_min, blank_sec, paused;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_min = 0, m_sec = 0;
    bit m_paused = 0, m_phase = 0, m_bmin = 0, m_bsec = 0;

    always #5 clk = ~clk;

    stopwatch_core #(.MIN_MAX(MIN_MAX), .SEC_MAX(SEC_MAX)) dut (
        .clk(clk), .rst(rst),
        .one_hz_tick(one_hz_tick), .two_hz_tick(two_hz_tick),
        .blink_tick(blink_tick), .pause_pulse(pause_pulse),
        .adj(adj), .sel(sel),
        .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones),
        .blank_min(blank_min), .blank_sec(blank_sec), .paused(paused)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int mm, input int ss);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [15:0] dut_time();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    // Apply rules in terms of whole minutes/seconds for the inputs present at this edge.
    task automatic model_step();
        bit was_paused;
        if (rst) begin
            m_min = 0; m_sec = 0; m_paused = 0; m_phase = 0;
        end else begin
            was_paused = m_paused;
            if (pause_pulse) m_paused = !m_paused;
            if (!adj) begin
                m_phase = 0;
                if (one_hz_tick && !was_paused) begin
                    if (m_sec == SEC_MAX) begin
                        m_sec = 0;
                        m_min = (m_min == MIN_MAX) ? 0 : m_min + 1;
                    end else begin
                        m_sec++;
                    end
                end
            end else begin
                if (blink_tick) m_phase = !m_phase;
                if (two_hz_tick) begin
                    if (sel) m_sec = (m_sec == SEC_MAX) ? 0 : m_sec + 1;
                    else     m_min = (m_min == MIN_MAX) ? 0 : m_min + 1;
                end
            end
        end
        m_bmin = !rst && adj && !sel && m_phase;
        m_bsec = !rst && adj && sel && m_phase;
    endtask

    // One clock cycle: drive pulses and levels, advance model, compare after the edge.
    task automatic cyc(input bit r, input bit t1, input bit t2, input bit bt,
                       input bit pp, input bit a, input bit s);
        rst = r; one_hz_tick = t1; two_hz_tick = t2; blink_tick = bt;
        pause_pulse = pp; adj = a; sel = s;
        @(posedge clk);
        model_step();
        #1;
        check_eq("time", 32'(dut_time()), 32'(to_bcd(m_min, m_sec)));
        check_eq("paused", 32'(paused), 32'(m_paused));
        check_eq("blank", {30'd0, blank_min, blank_sec}, {30'd0, m_bmin, m_bsec});
        rst = 0; one_hz_tick = 0; two_hz_tick = 0; blink_tick = 0; pause_pulse = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, adj, sel);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic preload(input int mm, input int ss);
        do_reset();
        for (int i = 0; i < mm; i++) cyc(0, 0, 1, 0, 0, 1, 0);
        for (int i = 0; i < ss; i++) cyc(0, 0, 1, 0, 0, 1, 1);
    endtask

    initial begin
        // Reset state
        do_reset();
        check_eq("rst_time", 32'(dut_time()), 32'h0000);
        check_eq("rst_flags", {29'd0, paused, blank_min, blank_sec}, 32'd0);

        // 61 seconds of counting
        for (int i = 0; i < 61; i++) begin
            cyc(0, 1, 0, 0, 0, 0, 0);
            idle(9);
        end
        check_eq("count_0101", 32'(dut_time()), 32'h0101);
        check_eq("count_paused", 32'(paused), 32'd0);

        // Full wrap
        preload(99, 58);
        cyc(0, 1, 0, 0, 0, 0, 0);
        check_eq("wrap_9959", 32'(dut_time()), 32'h9959);
        cyc(0, 1, 0, 0, 0, 0, 0);
        check_eq("wrap_0000", 32'(dut_time()), 32'h0000);

        // Pause coincident with a tick
        do_reset();
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0, 0);
        check_eq("pause_0006", 32'(dut_time()), 32'h0006);
        check_eq("pause_set", 32'(paused), 32'd1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 0);
        check_eq("pause_hold", 32'(dut_time()), 32'h0006);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        check_eq("resume_0007", 32'(dut_time()), 32'h0007);

        // Adjust seconds without carry, then minutes through the wrap
        preload(12, 57);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, (i < 3), 0, 0, 1, 1);
            cyc(0, 1, 0, 0, 0, 1, 1);
        end
        check_eq("adj_sec_1200", 32'(dut_time()), 32'h1200);
        for (int i = 0; i < 88; i++) cyc(0, 0, 1, 0, 0, 1, 0);
        check_eq("adj_min_0000", 32'(dut_time()), 32'h0000);

        // Blink on the minutes field
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1, 0, 1, 0);
            check_eq("blink_min", {30'd0, blank_min, blank_sec}, {30'd0, (i % 2 == 0), 1'b0});
            idle(2);
        end
        cyc(0, 0, 0, 1, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check_eq("blink_drop", {30'd0, blank_min, blank_sec}, 32'd0);

        // Reset dominates a simultaneous step and pause
        preload(45, 30);
        cyc(0, 0, 0, 1, 0, 1, 1);
        cyc(1, 0, 1, 0, 1, 1, 1);
        check_eq("rst_adj_time", 32'(dut_time()), 32'h0000);
        check_eq("rst_adj_flags", {29'd0, paused, blank_min, blank_sec}, 32'd0);

        // Random enables and levels
        for (int i = 0; i < 6000; i++) begin
            cyc(($urandom_range(0, 399) == 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 63) == 0) ? !adj : adj,
                ($urandom_range(0, 31) == 0) ? !sel : sel);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
